// File: rtl/fifo_xfer_ctrl.sv
// rtl/fifo_xfer_ctrl.sv - length-programmed source-to-sink FIFO transfer sequencer
// Issues source reads under empty/almost-full/outstanding throttling and registers returned data into the sink.
module fifo_xfer_ctrl #(
  parameter int DW      = 32,
  parameter int LEN_W   = 16,
  parameter int MAX_OUT = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [LEN_W-1:0] LEN,
  input  logic             ABORT,
  input  logic             SRC_EMPTY,
  input  logic             SRC_VALID,
  input  logic [DW-1:0]    SRC_DOUT,
  output logic             SRC_RD,
  input  logic             SNK_ALMOSTFULL,
  input  logic             SNK_FULL,
  output logic             SNK_WR,
  output logic [DW-1:0]    SNK_DIN,
  output logic             BUSY,
  output logic             DONE,
  output logic [LEN_W-1:0] WR_CNT,
  output logic             OVF,
  output logic             SPUR
);

  localparam int OW = $clog2(MAX_OUT + 1);
  localparam logic [OW-1:0] MAX_OUT_C = OW'(MAX_OUT);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] rd_cnt, rd_cnt_nxt;
  logic [OW-1:0]    outstd;
  logic             ret_ok;

  // Returned data only counts when a read is actually awaiting it.
  assign ret_ok = SRC_VALID && (outstd != '0);
  assign BUSY   = (state != S_IDLE);
  assign DONE   = (state == S_DONE);

  always_comb begin
    state_nxt  = state;
    SRC_RD     = 1'b0;
    rd_cnt_nxt = rd_cnt;
    case (state)
      S_IDLE: begin
        if (START) state_nxt = (LEN == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        SRC_RD = !ABORT && !SRC_EMPTY && !SNK_ALMOSTFULL &&
                 (outstd < MAX_OUT_C) && (rd_cnt < len_q);
        rd_cnt_nxt = rd_cnt + LEN_W'(SRC_RD);
        if (ABORT || (rd_cnt_nxt == len_q)) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if ((outstd == '0) && !SNK_WR) state_nxt = S_DONE;
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= S_IDLE;
      len_q   <= '0;
      rd_cnt  <= '0;
      outstd  <= '0;
      SNK_WR  <= 1'b0;
      SNK_DIN <= '0;
      WR_CNT  <= '0;
      OVF     <= 1'b0;
      SPUR    <= 1'b0;
    end else begin
      state  <= state_nxt;
      rd_cnt <= rd_cnt_nxt;
      outstd <= outstd + OW'(SRC_RD) - OW'(ret_ok);
      SNK_WR <= 1'b0;
      if ((state == S_IDLE) && START) begin
        len_q  <= LEN;
        rd_cnt <= '0;
        WR_CNT <= '0;
        OVF    <= 1'b0;
        SPUR   <= 1'b0;
      end
      // Return path runs in every state; a full sink drops the word and flags it.
      if (SRC_VALID) begin
        if (outstd == '0) begin
          SPUR <= 1'b1;
        end else if (SNK_FULL) begin
          OVF <= 1'b1;
        end else begin
          SNK_WR  <= 1'b1;
          SNK_DIN <= SRC_DOUT;
          if (WR_CNT < len_q) WR_CNT <= WR_CNT + LEN_W'(1);
        end
      end
    end
  end

endmodule

// File: doc/fifo_xfer_ctrl.md
# fifo_xfer_ctrl

Transfer sequencer that moves a programmed number of words from a source FIFO to a sink FIFO, driving the source read strobe and the sink write strobe from the FIFO status flags. It sits between two FIFOs in the streaming datapath, is started by a control master with a length, and reports busy/done plus sticky error flags. Read issue is throttled by source empty, sink almost-full and a limit on reads whose data has not yet returned.

## Interface
- DW, 32, data width
- LEN_W, 16, transfer length counter width
- MAX_OUT, 4, maximum reads issued whose data has not yet returned (1..15)

Clock and reset: one clock; reset is synchronous and active-high.

- CLK  in  1  clock
- RST  in  1  synchronous reset, active-high
- START  in  1  start pulse, sampled only in IDLE
- LEN  in  LEN_W  word count, captured with START
- ABORT  in  1  stop issuing reads, drain outstanding data
- SRC_EMPTY  in  1  source FIFO empty
- SRC_VALID  in  1  source read data valid
- SRC_DOUT  in  DW  source read data
- SRC_RD  out  1  source read strobe (combinational)
- SNK_ALMOSTFULL  in  1  sink FIFO almost full
- SNK_FULL  in  1  sink FIFO full
- SNK_WR  out  1  sink write strobe (registered)
- SNK_DIN  out  DW  sink write data (registered)
- BUSY  out  1  transfer in progress
- DONE  out  1  one-cycle completion pulse
- WR_CNT  out  LEN_W  words written in current or last transfer
- OVF  out  1  sticky: write attempted while SNK_FULL
- SPUR  out  1  sticky: SRC_VALID with zero outstanding

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: START=1 captures LEN, clears rd_cnt, WR_CNT, OVF and SPUR. LEN=0 goes to DONE. Otherwise goes to RUN.
- RUN: SRC_RD = !SRC_EMPTY & !SNK_ALMOSTFULL & (outstanding < MAX_OUT) & (rd_cnt < LEN).
  - Each SRC_RD increments rd_cnt and outstanding.
  - rd_cnt reaching LEN, or ABORT=1, moves to DRAIN. ABORT forces SRC_RD=0 in the same cycle.
- DRAIN: SRC_RD=0. Moves to DONE when outstanding==0 and no write is pending in the output register.
- DONE: DONE=1 for exactly one cycle, then IDLE. WR_CNT holds until the next START.
- Return path, active in every state:
  - SRC_VALID=1 with outstanding>0: decrement outstanding; register SNK_DIN<=SRC_DOUT and SNK_WR<=1 next cycle.
  - SRC_VALID=1 with outstanding==0: set SPUR; data dropped; no write.
- Write path: a pending write while SNK_FULL=1 sets OVF and is suppressed (SNK_WR=0). Otherwise SNK_WR=1 and WR_CNT increments.
- Sink almost-full threshold must leave at least MAX_OUT+1 free slots; OVF flags a violation of this.
- Counting:
  - Read issue and data return in the same cycle leave outstanding unchanged.
  - rd_cnt and WR_CNT never exceed LEN; no wrap.
  - outstanding width is ceil(log2(MAX_OUT+1)).
- START outside IDLE is ignored. ABORT outside RUN/DRAIN is ignored; ABORT in DRAIN has no further effect.
- RST in any state: state IDLE; all counters, flags and outputs 0; in-flight data discarded.

## Timing
- Reset values: SRC_RD=0, SNK_WR=0, SNK_DIN=0, BUSY=0, DONE=0, WR_CNT=0, OVF=0, SPUR=0.
- START at cycle t: BUSY=1 from t+1. First SRC_RD possible at t+1.
- SRC_RD follows SRC_EMPTY, SNK_ALMOSTFULL and ABORT in the same cycle (no registered lag), so back-to-back reads never underflow.
- SRC_VALID at cycle v gives SNK_WR at v+1. Sustained throughput is one word/cycle when not throttled.
- Last write at cycle w: DONE=1 at w+1 or later. BUSY falls in the cycle after DONE.
- LEN=0: DONE at t+1, BUSY high only during t+1.

## Test plan
- LEN=8, source holds 8 words, 1-cycle read latency, sink empty -> 8 consecutive SRC_RD, 8 SNK_WR with data in order, DONE pulse once, WR_CNT=8, OVF=SPUR=0.
- LEN=6, SRC_EMPTY toggles every other cycle, latency 3, MAX_OUT=2 -> outstanding never exceeds 2, SRC_RD never asserted while SRC_EMPTY=1, WR_CNT=6.
- LEN=10, SNK_ALMOSTFULL held high for cycles 3-7 -> no SRC_RD during those cycles, transfer resumes, completes with WR_CNT=10.
- LEN=20, ABORT after 5 reads with 2 outstanding -> SRC_RD drops the same cycle, 5 writes land, DONE, WR_CNT=5.
- SNK_FULL forced during a returning write -> OVF=1, that SNK_WR suppressed. SRC_VALID in IDLE -> SPUR=1, no write.
- RST asserted mid-RUN with reads outstanding -> next cycle all outputs 0, state IDLE; new START LEN=3 completes with WR_CNT=3.
